ped_signal_ctrl: RTL

- Pedestrian signal stage directly downstream of the one-way vehicle light controller.
- Consumes the vehicle red/yellow/green outputs and a 1 s tick from the system prescaler.
- Latches crossing requests and drives WALK / DONT_WALK heads, with a flashing clearance interval and a seconds countdown.
- Grants WALK only while vehicles hold steady red; any vehicle state change during WALK forces an immediate safe stop.

---
 rtl/ped_pkg.sv | 27 ++
 rtl/ped_req_sync.sv | 27 ++
 rtl/ped_signal_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian signal stage.
// Contents: controller state encoding, vehicle phase decode constants,
// default interval lengths and a lamp-combination legality helper.
package ped_pkg;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StHold  = 2'd1,
        StWalk  = 2'd2,
        StFlash = 2'd3
    } ped_state_e;

    // Vehicle phase decode on {red, yellow, green}
    localparam logic [2:0] PhIdle = 3'b000;
    localparam logic [2:0] PhStop = 3'b100;
    localparam logic [2:0] PhPrep = 3'b110;
    localparam logic [2:0] PhGo   = 3'b001;

    localparam int unsigned WalkTimeDefault  = 20;
    localparam int unsigned FlashTimeDefault = 8;
    localparam int unsigned CntWDefault      = 5;

    function automatic logic phase_legal(input logic [2:0] ph);
        return (ph == PhIdle) || (ph == PhStop) || (ph == PhPrep) || (ph == PhGo);
    endfunction

endpackage

// File: rtl/ped_req_sync.sv
// Push-button synchronizer: two flops bring the asynchronous level into the
// clk domain, a third holds the previous synchronized sample for edge detect.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   din   - asynchronous push-button level
//   pulse - one-clock pulse on a synchronized rising edge of din
module ped_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal controller downstream of the vehicle light controller.
// Grants WALK only on a red rising edge with a latched request, then runs a
// steady WALK interval followed by a flashing DONT_WALK clearance interval.
// Any departure from steady red during the interval aborts to DONT_WALK.
// Optional build macro: PED_COUNTDOWN_EN drives the countdown port; without
// it the port is tied to 0 (internal timing is unchanged).
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   tick_1s         - one-clock pulse per second
//   red/yellow/green- vehicle lamps
//   ped_req         - asynchronous push-button level
//   walk, dont_walk - pedestrian heads
//   req_pending     - request latched and not yet served
//   countdown       - seconds remaining in the walk interval, else 0
//   seq_err         - sticky illegal lamp combination flag
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned WALK_TIME  = WalkTimeDefault,
    parameter int unsigned FLASH_TIME = FlashTimeDefault,
    parameter int unsigned CNT_W      = CntWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1s,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_req,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             seq_err
);

    localparam logic [CNT_W-1:0] WalkCnt  = CNT_W'(WALK_TIME);
    localparam logic [CNT_W-1:0] FlashCnt = CNT_W'(FLASH_TIME);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    logic r_q, y_q, g_q, r_prev_q;
    logic [2:0] phase;
    logic illegal, red_rise, req_pulse, in_interval;

    ped_state_e state_q, state_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d, sec_dec;
    logic flash_ph_q, flash_ph_d;
    logic req_q, req_d;
    logic err_q, err_d;
    logic walk_q, walk_d;
    logic dw_q, dw_d;

    ped_req_sync u_req_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ped_req),
        .pulse (req_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q      <= 1'b0;
            y_q      <= 1'b0;
            g_q      <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_q      <= red;
            y_q      <= yellow;
            g_q      <= green;
            r_prev_q <= r_q;
        end
    end

    assign phase       = {r_q, y_q, g_q};
    assign illegal     = !phase_legal(phase);
    assign red_rise    = r_q & ~r_prev_q;
    assign in_interval = (state_q == StWalk) || (state_q == StFlash);
    // Saturating decrement; the counter never wraps below zero
    assign sec_dec     = (sec_cnt_q != '0) ? sec_cnt_q - CntOne : sec_cnt_q;

    always_comb begin
        state_d    = state_q;
        sec_cnt_d  = sec_cnt_q;
        flash_ph_d = flash_ph_q;
        req_d      = req_q;
        err_d      = err_q;

        if (req_pulse && !in_interval) begin
            req_d = 1'b1;
        end

        if (illegal) begin
            err_d      = 1'b1;
            state_d    = StHold;
            sec_cnt_d  = '0;
            flash_ph_d = 1'b0;
        end else if (phase == PhIdle) begin
            // Vehicle controller is dark or in reset: drop everything
            state_d    = StOff;
            sec_cnt_d  = '0;
            flash_ph_d = 1'b0;
            req_d      = 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StHold;
                end
                StHold: begin
                    // Only a fresh red edge starts WALK, never mid-phase
                    if (red_rise && (phase == PhStop) && req_q) begin
                        state_d   = StWalk;
                        sec_cnt_d = WalkCnt;
                        req_d     = 1'b0;
                    end
                end
                StWalk: begin
                    if (phase != PhStop) begin
                        state_d   = StHold;
                        sec_cnt_d = '0;
                    end else if (tick_1s) begin
                        sec_cnt_d = sec_dec;
                        if (sec_dec == FlashCnt) begin
                            state_d    = StFlash;
                            flash_ph_d = 1'b1;
                        end
                    end
                end
                StFlash: begin
                    if (phase != PhStop) begin
                        state_d    = StHold;
                        sec_cnt_d  = '0;
                        flash_ph_d = 1'b0;
                    end else if (tick_1s) begin
                        sec_cnt_d  = sec_dec;
                        flash_ph_d = ~flash_ph_q;
                        if (sec_dec == '0) begin
                            state_d    = StHold;
                            flash_ph_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end

        // Heads are registered from the next state so they move with it
        walk_d = (state_d == StWalk);
        unique case (state_d)
            StHold:  dw_d = 1'b1;
            StFlash: dw_d = flash_ph_d;
            default: dw_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StOff;
            sec_cnt_q  <= '0;
            flash_ph_q <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            walk_q     <= 1'b0;
            dw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_cnt_q  <= sec_cnt_d;
            flash_ph_q <= flash_ph_d;
            req_q      <= req_d;
            err_q      <= err_d;
            walk_q     <= walk_d;
            dw_q       <= dw_d;
        end
    end

`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] cd_q, cd_d;

    always_comb begin
        cd_d = '0;
        if ((state_d == StWalk) || (state_d == StFlash)) begin
            cd_d = sec_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end

    assign countdown = cd_q;
`else
    assign countdown = '0;
`endif

    assign walk        = walk_q;
    assign dont_walk   = dw_q;
    assign req_pending = req_q;
    assign seq_err     = err_q;

endmodule
